// File: rtl/uart_echo_buffer.sv
// Receive-to-transmit echo buffer: queues bytes from the UART receiver in a
// small FIFO and feeds them to the UART transmitter one frame at a time.
module uart_echo_buffer #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int ACK_TIMEOUT = 2000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          received,
  input  logic [7:0]    data_received,
  input  logic          transmitting,
  input  logic          transmitted,
  input  logic          clr_status,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic [AW:0]   fifo_count,
  output logic          empty,
  output logic          full,
  output logic          overrun,
  output logic          tx_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer, timer_nxt;
  logic          push, pop, timeout;

  // Flags come from the registered count only, so no input reaches them.
  assign empty = (fifo_count == '0);
  assign full  = (fifo_count == (AW+1)'(DEPTH));
  assign push  = received && !full;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pop       = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !transmitting) begin
          pop       = 1'b1;
          timer_nxt = '0;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A transmitter that finishes without a visible busy cycle is accepted.
        if (transmitted) begin
          state_nxt = IDLE;
        end else if (transmitting) begin
          timer_nxt = '0;
          state_nxt = WAIT_DONE;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          timeout   = 1'b1;
          timer_nxt = '0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (transmitted) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      overrun    <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      tx_start <= pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      // Setting a sticky flag takes priority over clearing it.
      if (received && full) overrun <= 1'b1;
      else if (clr_status)  overrun <= 1'b0;
      if (timeout)          tx_err  <= 1'b1;
      else if (clr_status)  tx_err  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_received;
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Scoreboard bench for uart_echo_buffer with a behavioural UART transmitter model.
module tb_uart_echo_buffer;

  localparam int DEPTH       = 16;
  localparam int AW          = 4;
  localparam int ACK_TIMEOUT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        received;
  logic [7:0]  data_received;
  logic        transmitted;
  logic        clr_status;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [AW:0] fifo_count;
  logic        empty, full, overrun, tx_err;

  logic        model_busy = 1'b0;
  logic        hold_busy  = 1'b0;
  logic        never_ack  = 1'b0;
  wire         transmitting = model_busy | hold_busy;

  int          frame_len = 20;
  int          frames = 0;
  int          starts = 0;
  int          cyc = 0;
  int          last_start_cyc = 0;
  int          done_edge = 0;
  logic        lat_armed = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q [$];

  uart_echo_buffer #(.DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .received(received), .data_received(data_received),
    .transmitting(transmitting), .transmitted(transmitted), .clr_status(clr_status),
    .tx_start(tx_start), .tx_data(tx_data), .fifo_count(fifo_count),
    .empty(empty), .full(full), .overrun(overrun), .tx_err(tx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    received      = 1'b1;
    data_received = b;
    exp_q.push_back(b);
    tick();
    received      = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin tick(); n++; end
    if (frames < target) check_eq("frame_wait", frames, target);
  endtask

  task automatic wait_start(input int s0, input int budget);
    int n = 0;
    while (starts == s0 && n < budget) begin tick(); n++; end
    if (starts == s0) check_eq("start_wait", starts, s0 + 1);
  endtask

  // Transmitter model: busy for frame_len cycles, then a one-cycle done pulse.
  initial begin
    transmitted = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !never_ack) begin
        model_busy = 1'b1;
        repeat (frame_len) @(negedge clk);
        model_busy  = 1'b0;
        transmitted = 1'b1;
        if (fifo_count != 0 && !hold_busy) begin
          lat_armed = 1'b1;
          done_edge = cyc + 1;
        end
        @(negedge clk);
        transmitted = 1'b0;
        frames++;
      end
    end
  end

  // Scoreboard side: every tx_start must present the oldest queued byte.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        starts++;
        last_start_cyc = cyc;
        check_eq("start_has_exp", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("tx_data", int'(tx_data), int'(exp_q.pop_front()));
        if (lat_armed) check_eq("b2b_lat", cyc, done_edge + 1);
        lat_armed = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, f0, s_cyc, e_cyc, prev, simul, n;
    logic pushed, popped;
    rst = 1'b1; received = 1'b0; data_received = '0; clr_status = 1'b0;
    repeat (3) tick();
    check_eq("rst_tx_start", int'(tx_start), 0);
    check_eq("rst_tx_data", int'(tx_data), 0);
    check_eq("rst_count", int'(fifo_count), 0);
    check_eq("rst_empty", int'(empty), 1);
    check_eq("rst_full", int'(full), 0);
    check_eq("rst_overrun", int'(overrun), 0);
    check_eq("rst_tx_err", int'(tx_err), 0);
    rst = 1'b0;
    tick();

    // Single byte with a full-length frame
    frame_len = 8680;
    s0 = starts; f0 = frames;
    push_byte(8'h41);
    check_eq("single_cnt1", int'(fifo_count), 1);
    check_eq("single_nostart", int'(tx_start), 0);
    tick();
    check_eq("single_start", int'(tx_start), 1);
    check_eq("single_cnt0", int'(fifo_count), 0);
    wait_frames(f0 + 1, 9000);
    repeat (20) tick();
    check_eq("single_one_start", starts, s0 + 1);

    // Burst while the transmitter is held busy
    frame_len = 20;
    hold_busy = 1'b1;
    tick();
    s0 = starts; f0 = frames;
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    check_eq("burst_peak", int'(fifo_count), 3);
    check_eq("burst_held", starts, s0);
    hold_busy = 1'b0;
    wait_frames(f0 + 3, 500);
    check_eq("burst_drained", int'(exp_q.size()), 0);

    // Overrun: 17 bytes into a 16-entry FIFO, clear collides with the drop
    hold_busy = 1'b1;
    tick();
    f0 = frames;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check_eq("ovr_full", int'(full), 1);
    check_eq("ovr_cnt16", int'(fifo_count), DEPTH);
    check_eq("ovr_not_yet", int'(overrun), 0);
    received = 1'b1; data_received = 8'h10; clr_status = 1'b1;
    tick();
    received = 1'b0; clr_status = 1'b0;
    check_eq("ovr_set_wins", int'(overrun), 1);
    check_eq("ovr_cnt_kept", int'(fifo_count), DEPTH);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check_eq("ovr_cleared", int'(overrun), 0);
    hold_busy = 1'b0;
    wait_frames(f0 + 16, 1500);
    check_eq("ovr_drained", int'(exp_q.size()), 0);

    // Continuous pushes across pointer wrap, with pushes landing on pop edges
    frame_len = 4;
    f0 = frames; simul = 0;
    for (int i = 0; i < 40;) begin
      prev   = int'(fifo_count);
      pushed = !full;
      if (pushed) begin
        received      = 1'b1;
        data_received = 8'($urandom_range(0, 255));
        exp_q.push_back(data_received);
        i++;
      end
      tick();
      received = 1'b0;
      popped   = tx_start;
      check_eq("wrap_cnt", int'(fifo_count), prev + int'(pushed) - int'(popped));
      if (pushed && popped) simul++;
    end
    wait_frames(f0 + 40, 1000);
    check_eq("wrap_simul_seen", int'(simul > 0), 1);
    check_eq("wrap_drained", int'(exp_q.size()), 0);

    // Handshake timeout, then the next byte still goes out
    never_ack = 1'b1;
    s0 = starts;
    push_byte(8'h55);
    wait_start(s0, 10);
    s_cyc = last_start_cyc;
    push_byte(8'h66);
    n = 0;
    while (!tx_err && n < ACK_TIMEOUT + 20) begin tick(); n++; end
    e_cyc = cyc;
    check_eq("tmo_flag", int'(tx_err), 1);
    check_eq("tmo_lat", e_cyc - s_cyc, ACK_TIMEOUT);
    never_ack = 1'b0;
    f0 = frames;
    tick();
    check_eq("tmo_next_start", int'(tx_start), 1);
    wait_frames(f0 + 1, 200);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check_eq("tmo_cleared", int'(tx_err), 0);

    // Reset in the middle of a frame with bytes queued
    frame_len = 60;
    s0 = starts;
    push_byte(8'h11);
    wait_start(s0, 10);
    tick();
    push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    check_eq("rmid_cnt3", int'(fifo_count), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_eq("rmid_empty", int'(empty), 1);
    check_eq("rmid_cnt0", int'(fifo_count), 0);
    check_eq("rmid_full", int'(full), 0);
    check_eq("rmid_overrun", int'(overrun), 0);
    check_eq("rmid_tx_err", int'(tx_err), 0);
    check_eq("rmid_tx_start", int'(tx_start), 0);
    s0 = starts;
    repeat (100) tick();
    check_eq("rmid_quiet", starts, s0);
    f0 = frames;
    push_byte(8'h99);
    wait_frames(f0 + 1, 200);
    check_eq("rmid_resume", starts, s0 + 1);
    check_eq("final_drained", int'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
